mux8way16_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one Mux8Way16 datapath among 8 requesters (a..h). It picks one requester and locks the mux select. It presents the selected 16-bit word downstream under a valid/ready handshake and returns a one-cycle ack to the winner. It sits between the requester-side gate datapaths and a single consumer, such as a future register or ALU input.

---
 rtl/mux8way16_rr_arbiter_pkg.sv | 33 +++
 rtl/Mux8Way16.sv | 32 +++
 rtl/rr_pick8.sv | 36 +++
 rtl/mux8way16_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux8way16_rr_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mux8way16_rr_arbiter_pkg.sv
// rtl/mux8way16_rr_arbiter_pkg.sv - shared constants, state type and select helpers
// Purpose: widths, state encoding and select/index conversion used by the arbiter.
// Select vectors are declared [0:SEL_W-1] with index = sel[0] + 2*sel[1] + 4*sel[2],
// so bit i of a select always carries weight 2**i; the helpers convert to and from
// ordinary [SEL_W-1:0] numeric indices.
package mux8way16_rr_arbiter_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 16;
    localparam int NREQ   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [0:SEL_W-1] idx_to_sel(input logic [SEL_W-1:0] idx);
        logic [0:SEL_W-1] s;
        for (int i = 0; i < SEL_W; i++) begin
            s[i] = idx[i];
        end
        return s;
    endfunction

    function automatic logic [SEL_W-1:0] sel_to_idx(input logic [0:SEL_W-1] s);
        logic [SEL_W-1:0] idx;
        for (int i = 0; i < SEL_W; i++) begin
            idx[i] = s[i];
        end
        return idx;
    endfunction

endpackage

// File: rtl/Mux8Way16.sv
// rtl/Mux8Way16.sv - 8-way 16-bit multiplexer datapath
// Purpose: selects one of eight 16-bit words.
// Ports: a..h data words [0:15]; sel [0:2] with index = sel[0] + 2*sel[1] + 4*sel[2];
//        out selected word [0:15].
module Mux8Way16 (
    input  logic [0:15] a,
    input  logic [0:15] b,
    input  logic [0:15] c,
    input  logic [0:15] d,
    input  logic [0:15] e,
    input  logic [0:15] f,
    input  logic [0:15] g,
    input  logic [0:15] h,
    input  logic [0:2]  sel,
    output logic [0:15] out
);

    always_comb begin
        out = a;
        case ({sel[2], sel[1], sel[0]})
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            default: out = h;
        endcase
    end

endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin priority pick over 8 requests
// Purpose: finds the first set request scanning upward from (last+1) mod 8 with wrap.
// Ports: req [0:7] (req[0]=a); last [0:2] previously served select;
//        winner [0:2] chosen select; any = at least one request set.
module rr_pick8
    import mux8way16_rr_arbiter_pkg::*;
(
    input  logic [0:NREQ-1]  req,
    input  logic [0:SEL_W-1] last,
    output logic [0:SEL_W-1] winner,
    output logic             any
);

    logic [SEL_W-1:0] last_idx;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W-1:0] cand;

    assign last_idx = sel_to_idx(last);

    // Scan offsets from farthest to nearest so the nearest set request is the
    // last one written and therefore wins. Offset 8 wraps back onto last itself.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = last_idx + 3'(i) + 3'd1;
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    assign winner = idx_to_sel(win_idx);
    assign any    = |req;

endmodule

// File: rtl/mux8way16_rr_arbiter.sv
// rtl/mux8way16_rr_arbiter.sv - round-robin arbiter sharing one Mux8Way16 among 8 requesters
// Purpose: grants one requester at a time, locks the mux select, presents the word under
// a valid/ready handshake and pulses a registered one-hot ack to the winner.
// Ports: clock, reset (sync, active-high); req [0:7]; a..h data words [0:15];
//        out [0:15] mux output; out_valid; out_ready; ack [0:7] one-cycle one-hot;
//        sel [0:2] current select; busy = in GRANT.
// BURST: max consecutive transfers for one requester before re-arbitration (1..15).
module mux8way16_rr_arbiter
    import mux8way16_rr_arbiter_pkg::*;
#(
    parameter int BURST = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [0:NREQ-1]   req,
    input  logic [0:DATA_W-1] a,
    input  logic [0:DATA_W-1] b,
    input  logic [0:DATA_W-1] c,
    input  logic [0:DATA_W-1] d,
    input  logic [0:DATA_W-1] e,
    input  logic [0:DATA_W-1] f,
    input  logic [0:DATA_W-1] g,
    input  logic [0:DATA_W-1] h,
    output logic [0:DATA_W-1] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:NREQ-1]   ack,
    output logic [0:SEL_W-1]  sel,
    output logic              busy
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [3:0]       burst_q, burst_d;
    logic [0:NREQ-1]  ack_q, ack_d;

    logic [0:SEL_W-1] pick_last;
    logic [0:SEL_W-1] pick_winner;
    logic             pick_any;
    logic             xfer;
    logic [3:0]       burst_inc;
    logic             burst_more;

    assign pick_last = idx_to_sel(last_q);

    rr_pick8 u_pick (
        .req    (req),
        .last   (pick_last),
        .winner (pick_winner),
        .any    (pick_any)
    );

    Mux8Way16 u_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .e   (e),
        .f   (f),
        .g   (g),
        .h   (h),
        .sel (sel),
        .out (out)
    );

    assign sel       = idx_to_sel(sel_q);
    assign busy      = (state_q == GRANT);
    assign out_valid = (state_q == GRANT) && req[sel_q];
    assign ack       = ack_q;
    assign xfer      = out_valid && out_ready;

    // Saturating count so a large BURST can never wrap back to zero.
    assign burst_inc  = (burst_q == 4'hF) ? 4'hF : burst_q + 4'd1;
    assign burst_more = ({1'b0, burst_q} + 5'd1) < 5'(BURST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        burst_d = burst_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = sel_to_idx(pick_winner);
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    // Requester withdrew: give up the grant without an ack.
                    last_d  = sel_q;
                    state_d = IDLE;
                end else if (xfer) begin
                    ack_d[sel_q] = 1'b1;
                    burst_d      = burst_inc;
                    if (!burst_more) begin
                        last_d  = sel_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= 3'd7;
            burst_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            ack_q   <= ack_d;
        end
    end

endmodule

// File: tb/tb_mux8way16_rr_arbiter.sv
// tb/tb_mux8way16_rr_arbiter.sv - directed self-checking bench for mux8way16_rr_arbiter
module tb_mux8way16_rr_arbiter;

    logic        clock;
    logic        reset;
    logic [0:7]  req;
    logic [0:15] a, b, c, d, e, f, g, h;
    logic        out_ready;

    logic [0:15] out1, out3;
    logic        ov1, ov3;
    logic [0:7]  ack1, ack3;
    logic [0:2]  sel1, sel3;
    logic        busy1, busy3;

    int n_cmp;
    int n_err;

    mux8way16_rr_arbiter #(.BURST(1)) u_dut1 (
        .clock(clock), .reset(reset), .req(req),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out(out1), .out_valid(ov1), .out_ready(out_ready),
        .ack(ack1), .sel(sel1), .busy(busy1)
    );

    mux8way16_rr_arbiter #(.BURST(3)) u_dut3 (
        .clock(clock), .reset(reset), .req(req),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out(out3), .out_valid(ov3), .out_ready(out_ready),
        .ack(ack3), .sel(sel3), .busy(busy3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Select vector for requester index k: sel[i] carries weight 2**i.
    function automatic logic [0:2] sel_of(input int k);
        logic [2:0] t;
        t = k[2:0];
        return {t[0], t[1], t[2]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        a = 16'hA0A0; b = 16'hB1B1; c = 16'h1234; d = 16'hD3D3;
        e = 16'hE4E4; f = 16'hF5F5; g = 16'h6666; h = 16'h7777;
        reset = 1'b1; req = '0; out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_valid", ov1, 0);
        check_eq("rst_ack", ack1, 0);
        check_eq("rst_busy", busy1, 0);
        check_eq("rst_sel", sel1, 0);

        // Single request from c
        reset = 1'b0; req = 8'b00100000; out_ready = 1'b1;
        tick();
        check_eq("c_valid", ov1, 1);
        check_eq("c_out", out1, 16'h1234);
        check_eq("c_sel", sel1, 3'b010);
        check_eq("c_ack_early", ack1, 0);
        tick();
        check_eq("c_ack", ack1, 8'b00100000);
        check_eq("c_idle", busy1, 0);
        req = '0;
        tick();
        check_eq("c_ack_pulse", ack1, 0);

        // All eight held, BURST=1: a..h then a, two cycles per transfer
        do_reset();
        req = 8'hFF; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_eq("rr_sel", sel1, sel_of(k % 8));
            check_eq("rr_valid", ov1, 1);
            check_eq("rr_ack_none", ack1, 0);
            tick();
            check_eq("rr_ack", ack1, 8'h80 >> (k % 8));
            check_eq("rr_gap", busy1, 0);
        end

        // Backpressure on a
        do_reset();
        req = 8'h80; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", ov1, 1);
            check_eq("bp_sel", sel1, 0);
            check_eq("bp_ack", ack1, 0);
        end
        check_eq("bp_out", out1, 16'hA0A0);
        out_ready = 1'b1;
        tick();
        check_eq("bp_ack_accept", ack1, 8'h80);
        req = '0;
        tick();
        check_eq("bp_ack_pulse", ack1, 0);

        // Withdrawal by e, then scan resumes at f
        do_reset();
        req = 8'b00001000; out_ready = 1'b0;
        tick();
        check_eq("wd_valid", ov1, 1);
        check_eq("wd_sel", sel1, sel_of(4));
        req = '0;
        tick();
        check_eq("wd_valid_drop", ov1, 0);
        check_eq("wd_ack", ack1, 0);
        check_eq("wd_idle", busy1, 0);
        req = 8'b10011100;
        tick();
        check_eq("wd_next_sel", sel1, sel_of(5));
        check_eq("wd_next_out", out1, 16'hF5F5);

        // BURST=3 with b and d held
        do_reset();
        req = 8'b01010000; out_ready = 1'b1;
        tick();
        check_eq("b3_sel_b", sel3, sel_of(1));
        check_eq("b3_valid", ov3, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("b3_ack_b", ack3, 8'h40);
            check_eq("b3_hold", ov3, 1);
        end
        tick();
        check_eq("b3_ack_b_last", ack3, 8'h40);
        check_eq("b3_gap_busy", busy3, 0);
        check_eq("b3_gap_valid", ov3, 0);
        tick();
        check_eq("b3_sel_d", sel3, sel_of(3));
        check_eq("b3_gap_ack", ack3, 0);
        tick();
        check_eq("b3_ack_d", ack3, 8'h10);

        // Reset while granted with out_valid=1
        do_reset();
        req = 8'h04; out_ready = 1'b0;
        tick();
        check_eq("mr_valid", ov1, 1);
        check_eq("mr_sel", sel1, sel_of(5));
        reset = 1'b1; out_ready = 1'b1;
        tick();
        check_eq("mr_valid_rst", ov1, 0);
        check_eq("mr_ack_rst", ack1, 0);
        check_eq("mr_busy_rst", busy1, 0);
        check_eq("mr_sel_rst", sel1, 0);
        reset = 1'b0; req = 8'hFF;
        tick();
        check_eq("mr_next_sel", sel1, 0);
        check_eq("mr_next_valid", ov1, 1);
        tick();
        check_eq("mr_next_ack", ack1, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
